// File: rtl/store_capture_unit.sv
// Store capture unit: watches CPU stores, buffers in-window stores with a cycle
// timestamp in a FIFO, and latches misaligned/halt status flags.
module store_capture_unit #(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] WIN_LO    = 32'h0000_0000,
   parameter logic [31:0] WIN_HI    = 32'h0000_00FF,
   parameter logic [31:0] HALT_ADDR = 32'h0000_FFFC
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       memwrite,
   input  logic [31:0]                dataadr,
   input  logic [31:0]                writedata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_addr,
   output logic [31:0]                out_data,
   output logic [15:0]                out_cycle,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic [7:0]                 drop_count,
   output logic                       misaligned,
   output logic                       halted,
   output logic [31:0]                halt_code
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [15:0] cyc;
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [15:0]     cycle_q, cycle_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      drop_count_q, drop_count_d;
   logic            misaligned_q, misaligned_d;
   logic            halted_q, halted_d;
   logic [31:0]     halt_code_q, halt_code_d;

   logic is_store, is_mis, is_halt, in_win, is_cap;
   logic full, pop, push, drop;
   entry_t head;

   always_comb begin
      is_store = memwrite && !halted_q;
      is_mis   = (dataadr[1:0] != 2'b00);
      is_halt  = !is_mis && (dataadr == HALT_ADDR);
      // Offset compare avoids a constant-true test when WIN_LO is zero.
      in_win   = ((dataadr - WIN_LO) <= (WIN_HI - WIN_LO));
      is_cap   = is_store && !is_mis && !is_halt && in_win;

      full = (count_q == CW'(DEPTH));
      pop  = out_valid && out_ready;
      push = is_cap && (!full || pop);
      drop = is_cap && full && !pop;

      cycle_d      = cycle_q + 16'd1;
      wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d      = count_q;
      if (push && !pop) count_d = count_q + CW'(1);
      if (pop && !push) count_d = count_q - CW'(1);

      overflow_d   = overflow_q || drop;
      drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
      misaligned_d = misaligned_q || (is_store && is_mis);
      halted_d     = halted_q || (is_store && is_halt);
      halt_code_d  = (is_store && is_halt) ? writedata : halt_code_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         cycle_q      <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
         misaligned_q <= 1'b0;
         halted_q     <= 1'b0;
         halt_code_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         cycle_q      <= cycle_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
         misaligned_q <= misaligned_d;
         halted_q     <= halted_d;
         halt_code_q  <= halt_code_d;
      end
   end

   // Storage needs no reset: outputs are masked whenever count is zero.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= '{cyc: cycle_q, addr: dataadr, data: writedata};
      end
   end

   assign head       = mem_q[rd_ptr_q];
   assign out_valid  = (count_q != '0);
   assign out_addr   = out_valid ? head.addr : 32'd0;
   assign out_data   = out_valid ? head.data : 32'd0;
   assign out_cycle  = out_valid ? head.cyc  : 16'd0;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;
   assign misaligned = misaligned_q;
   assign halted     = halted_q;
   assign halt_code  = halt_code_q;

endmodule

// File: tb/tb_store_capture_unit.sv
// Self-checking bench for store_capture_unit: scoreboard of expected FIFO
// entries, one task per scenario, single summary line at the end.
module tb_store_capture_unit;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [15:0] out_cycle;
   logic [3:0]  count;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        misaligned;
   logic        halted;
   logic [31:0] halt_code;

   int          n_tests;
   int          n_fail;
   logic [79:0] exp_q[$];
   logic [15:0] tb_cyc;

   store_capture_unit dut (
      .clk        (clk),
      .reset      (reset),
      .memwrite   (memwrite),
      .dataadr    (dataadr),
      .writedata  (writedata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .out_cycle  (out_cycle),
      .count      (count),
      .overflow   (overflow),
      .drop_count (drop_count),
      .misaligned (misaligned),
      .halted     (halted),
      .halt_code  (halt_code)
   );

   // Clock and reference cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) tb_cyc <= reset ? 16'd0 : tb_cyc + 16'd1;

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic exp_push);
      memwrite  = mw;
      dataadr   = a;
      writedata = d;
      out_ready = rdy;
      if (exp_push) exp_q.push_back({tb_cyc, a, d});
      step();
      memwrite  = 1'b0;
      out_ready = 1'b0;
   endtask

   // Scenario tasks
   task automatic test_reset();
      reset = 1'b1; memwrite = 1'b1; dataadr = 32'h20; writedata = 32'h11; out_ready = 1'b0;
      step();
      step();
      reset = 1'b0; memwrite = 1'b0;
      n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d req 0", count); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b req 0", out_valid); end
      n_tests++; if ({overflow, misaligned, halted} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b req 000", {overflow, misaligned, halted}); end
      n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %h req 00", drop_count); end
      n_tests++; if (halt_code !== 32'd0) begin n_fail++; $display("FAIL reset_halt_code: got %h req 0", halt_code); end
      n_tests++; if ({out_cycle, out_addr, out_data} !== 80'd0) begin n_fail++; $display("FAIL reset_out_zero: got %h req 0", {out_cycle, out_addr, out_data}); end
   endtask

   task automatic test_single();
      for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      drive(1'b1, 32'h24, 32'd7, 1'b1, 1'b1);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b req 1", out_valid); end
      n_tests++;
      if ({out_cycle, out_addr, out_data} !== {16'd3, 32'h24, 32'd7}) begin
         n_fail++; $display("FAIL single_entry: got %h req %h", {out_cycle, out_addr, out_data}, {16'd3, 32'h24, 32'd7});
      end
      n_tests++;
      if (exp_q.size() == 0 || {out_cycle, out_addr, out_data} !== exp_q[0]) begin
         n_fail++; $display("FAIL single_scoreboard: got %h", {out_cycle, out_addr, out_data});
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b req 0", out_valid); end
      n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL single_empty_data: got %h req 0", out_data); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 10; i++) drive(1'b1, 32'h40 + 32'(4 * i), $urandom, 1'b0, i < 8);
      n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d req 8", count); end
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b req 1", overflow); end
      n_tests++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL ovf_drop: got %0d req 2", drop_count); end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (exp_q.size() == 0 || out_valid !== 1'b1 || {out_cycle, out_addr, out_data} !== exp_q[0]) begin
            n_fail++; $display("FAIL ovf_pop%0d: got v=%b %h", i, out_valid, {out_cycle, out_addr, out_data});
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d req 0", count); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 8; i++) drive(1'b1, 32'h80 + 32'(4 * i), $urandom, 1'b0, 1'b1);
      n_tests++;
      if (exp_q.size() == 0 || {out_cycle, out_addr, out_data} !== exp_q[0]) begin
         n_fail++; $display("FAIL pp_head: got %h", {out_cycle, out_addr, out_data});
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      drive(1'b1, 32'hF0, 32'hCAFE_F00D, 1'b1, 1'b1);
      n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL pp_count: got %0d req 8", count); end
      n_tests++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL pp_drop: got %0d req 2", drop_count); end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (exp_q.size() == 0 || out_valid !== 1'b1 || {out_cycle, out_addr, out_data} !== exp_q[0]) begin
            n_fail++; $display("FAIL pp_pop%0d: got v=%b %h", i, out_valid, {out_cycle, out_addr, out_data});
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 8; i++) drive(1'b1, 32'h10 + 32'(4 * i), $urandom, 1'b0, 1'b1);
      for (int i = 0; i < 260; i++) drive(1'b1, 32'(4 * $urandom_range(0, 63)), $urandom, 1'b0, 1'b0);
      n_tests++; if (drop_count !== 8'hFF) begin n_fail++; $display("FAIL sat_drop: got %h req FF", drop_count); end
      n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL sat_count: got %0d req 8", count); end
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (exp_q.size() == 0 || {out_cycle, out_addr, out_data} !== exp_q[0]) begin
            n_fail++; $display("FAIL sat_pop%0d: got %h", i, {out_cycle, out_addr, out_data});
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      n_tests++; if (count !== 4'd3) begin n_fail++; $display("FAIL sat_left: got %0d req 3", count); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; memwrite = 1'b1; dataadr = 32'h44; writedata = 32'h99; out_ready = 1'b0;
      step();
      reset = 1'b0; memwrite = 1'b0;
      exp_q.delete();
      n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL mid_count: got %0d req 0", count); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b req 0", out_valid); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b req 0", overflow); end
      n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL mid_drop: got %0d req 0", drop_count); end
      drive(1'b1, 32'h30, 32'h55, 1'b0, 1'b1);
      n_tests++; if (out_cycle !== 16'd0) begin n_fail++; $display("FAIL mid_cycle0: got %0d req 0", out_cycle); end
      n_tests++;
      if (exp_q.size() == 0 || out_valid !== 1'b1 || {out_cycle, out_addr, out_data} !== exp_q[0]) begin
         n_fail++; $display("FAIL mid_entry: got v=%b %h", out_valid, {out_cycle, out_addr, out_data});
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_misaligned();
      drive(1'b1, 32'h26, 32'h1234, 1'b0, 1'b0);
      drive(1'b1, 32'h400, 32'h5678, 1'b0, 1'b0);
      n_tests++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b req 1", misaligned); end
      n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL mis_count: got %0d req 0", count); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mis_overflow: got %b req 0", overflow); end
   endtask

   task automatic test_halt();
      drive(1'b1, 32'hFFFC, 32'hDEAD, 1'b0, 1'b0);
      n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b req 1", halted); end
      n_tests++; if (halt_code !== 32'hDEAD) begin n_fail++; $display("FAIL halt_code1: got %h req DEAD", halt_code); end
      drive(1'b1, 32'hFFFC, 32'hBEEF, 1'b0, 1'b0);
      drive(1'b1, 32'h10, 32'd1, 1'b0, 1'b0);
      n_tests++; if (halt_code !== 32'hDEAD) begin n_fail++; $display("FAIL halt_code2: got %h req DEAD", halt_code); end
      n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL halt_count: got %0d req 0", count); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b req 0", out_valid); end
   endtask

   // Test sequence and final report
   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; out_ready = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_saturate();
      test_reset_mid();
      test_misaligned();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
